// File: rtl/mul_req_pkg.sv
// Shared types and default sizing for the multiplier requester.
// The state enum is kept here so the top and any future siblings agree on encoding.
package mul_req_pkg;

    // Default operand width; products are twice this wide.
    localparam int DEF_DW      = 8;
    // Default number of WAIT clocks before an unanswered request is flagged.
    localparam int DEF_TIMEOUT = 16;
    // Default width of the completion and error statistics counters.
    localparam int DEF_CNT_W   = 16;

    // Request lifecycle: accept, pulse the multiplier, wait for ack, hand back the result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/mul_req_timeout.sv
// Timeout counter for the requester's WAIT state.
// It is cleared while a request is being issued and counts while waiting.
// 'o_expired' rises when the count reaches TIMEOUT-1, which is the last WAIT clock
// on which an ack can still be accepted.
module mul_req_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = (TIMEOUT <= 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] r_count;

    // Count WAIT clocks; park at the terminal value so the flag stays up until cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mul_requester.sv
// Initiator side of the multiplier en/ack handshake.
// Takes operand pairs from an upstream valid/ready stream, fires a one-cycle en pulse at
// the multiplier, waits a bounded time for ack and returns the product, or a timeout
// error, on a downstream valid/ready stream. Completions and timeouts are counted.
module mul_requester
    import mul_req_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DW-1:0]     req_a,
    input  logic [DW-1:0]     req_b,
    output logic [DW-1:0]     mul_a,
    output logic [DW-1:0]     mul_b,
    output logic              mul_en,
    input  logic [2*DW-1:0]   mul_out,
    input  logic              mul_ack,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2*DW-1:0]   rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [CNT_W-1:0]  done_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    state_t             r_state;
    logic [DW-1:0]      r_mul_a;
    logic [DW-1:0]      r_mul_b;
    logic               r_mul_en;
    logic               r_rsp_valid;
    logic [2*DW-1:0]    r_rsp_data;
    logic               r_rsp_err;
    logic [CNT_W-1:0]   r_done_cnt;
    logic [CNT_W-1:0]   r_err_cnt;

    logic               w_tmo_clear;
    logic               w_tmo_enable;
    logic               w_expired;

    // The timeout count restarts during ISSUE so every WAIT gets the full window.
    assign w_tmo_clear  = (r_state == ISSUE);
    assign w_tmo_enable = (r_state == WAIT);

    mul_req_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (w_tmo_clear),
        .i_enable  (w_tmo_enable),
        .o_expired (w_expired)
    );

    // Request FSM with registered outputs. mul_en is a default-low pulse that is only
    // raised on the accepting edge, so it is high for exactly the ISSUE cycle. Acks that
    // arrive outside WAIT fall through every branch and are ignored. Result registers are
    // only written on the WAIT exit, so they hold steady throughout RESP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_mul_en    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_done_cnt  <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_mul_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_mul_a  <= req_a;
                        r_mul_b  <= req_b;
                        r_mul_en <= 1'b1;
                        r_state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (mul_ack) begin
                        r_rsp_data  <= mul_out;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else if (w_expired) begin
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (r_rsp_err) begin
                            if (r_err_cnt != '1) begin
                                r_err_cnt <= r_err_cnt + 1'b1;
                            end
                        end else begin
                            if (r_done_cnt != '1) begin
                                r_done_cnt <= r_done_cnt + 1'b1;
                            end
                        end
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Upstream readiness and the busy flag depend on state alone.
    assign req_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);

    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign mul_en    = r_mul_en;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign done_cnt  = r_done_cnt;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_mul_requester.sv
// Bench for mul_requester, paired with a behavioural multiplier of programmable latency.
// Directed scenarios first, then randomized operations scored against a simple
// product/timeout model of what each request should return.
module tb_mul_requester;

    localparam int DW    = 8;
    localparam int TO    = 8;
    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic [DW-1:0]     req_a;
    logic [DW-1:0]     req_b;
    logic [DW-1:0]     mul_a;
    logic [DW-1:0]     mul_b;
    logic              mul_en;
    logic [2*DW-1:0]   mul_out = '0;
    logic              mul_ack = 1'b0;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2*DW-1:0]   rsp_data;
    logic              rsp_err;
    logic              busy;
    logic [CNT_W-1:0]  done_cnt;
    logic [CNT_W-1:0]  err_cnt;

    int total = 0;
    int bad   = 0;

    int        latCfg    = 1;
    bit        ackEnable = 1'b1;
    bit        strayAck  = 1'b0;
    int        countdown = 0;
    logic [DW-1:0] pa = '0;
    logic [DW-1:0] pb = '0;

    mul_requester #(
        .DW      (DW),
        .TIMEOUT (TO),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_en    (mul_en),
        .mul_out   (mul_out),
        .mul_ack   (mul_ack),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .done_cnt  (done_cnt),
        .err_cnt   (err_cnt)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Behavioural multiplier: ack arrives latCfg clocks after it samples en.
    // ackEnable=0 models a dead multiplier; strayAck forces a bogus one-cycle ack.
    always @(posedge clk) begin
        mul_ack <= 1'b0;
        if (mul_en) begin
            if (latCfg <= 1) begin
                mul_ack   <= ackEnable;
                mul_out   <= mul_a * mul_b;
                countdown <= 0;
            end else begin
                countdown <= latCfg - 1;
                pa        <= mul_a;
                pb        <= mul_b;
            end
        end else if (countdown > 0) begin
            countdown <= countdown - 1;
            if (countdown == 1) begin
                mul_ack <= ackEnable;
                mul_out <= pa * pb;
            end
        end
        if (strayAck) begin
            mul_ack <= 1'b1;
            mul_out <= 16'hDEAD;
        end
    end

    // Hard stop in case some wait below is miscounted.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    // One comparison: count it, and report tag/observed/expected on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present an operand pair on the upstream stream at the current negedge.
    task automatic applyStimulus(input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
    endtask

    // Step negedges until rsp_valid shows; cyc is the negedge index after the
    // accepting edge at which it appeared, or 0 if it never did.
    task automatic waitRsp(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (rsp_valid) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        int expDone;
        int expErr;
        logic [DW-1:0]   ra;
        logic [DW-1:0]   rb;
        logic [2*DW-1:0] expData;
        bit              expE;
        bit              handshook;

        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_mul_en",    mul_en,    0);
        checkOutput("rst_busy",      busy,      0);
        checkOutput("rst_done",      done_cnt,  0);
        checkOutput("rst_err",       err_cnt,   0);
        checkOutput("rst_data",      rsp_data,  0);
        checkOutput("rst_mul_a",     mul_a,     0);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] single op 4*10");
        rsp_ready = 1'b1;
        applyStimulus(8'd4, 8'd10);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("t1_mul_en_hi",  mul_en,    1);
        checkOutput("t1_mul_a",      mul_a,     4);
        checkOutput("t1_mul_b",      mul_b,     10);
        checkOutput("t1_req_ready",  req_ready, 0);
        checkOutput("t1_busy",       busy,      1);
        @(negedge clk);
        checkOutput("t1_mul_en_lo",  mul_en,    0);
        checkOutput("t1_no_rsp_yet", rsp_valid, 0);
        @(negedge clk);
        checkOutput("t1_rsp_valid",  rsp_valid, 1);
        checkOutput("t1_rsp_data",   rsp_data,  40);
        checkOutput("t1_rsp_err",    rsp_err,   0);
        @(negedge clk);
        checkOutput("t1_rsp_clear",  rsp_valid, 0);
        checkOutput("t1_done",       done_cnt,  1);
        checkOutput("t1_idle",       req_ready, 1);

        $display("[TB] back-to-back with stalled response");
        rsp_ready = 1'b0;
        applyStimulus(8'd6, 8'd12);
        waitRsp(cyc);
        checkOutput("t2_lat",  cyc,      3);
        checkOutput("t2_data", rsp_data, 72);
        applyStimulus(8'd8, 8'd16);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t2_hold_valid", rsp_valid, 1);
            checkOutput("t2_hold_data",  rsp_data,  72);
            checkOutput("t2_hold_ready", req_ready, 0);
            checkOutput("t2_hold_mul_a", mul_a,     6);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("t2_idle",  req_ready, 1);
        checkOutput("t2_done1", done_cnt,  2);
        waitRsp(cyc);
        checkOutput("t2_lat2",  cyc,      3);
        checkOutput("t2_data2", rsp_data, 128);
        checkOutput("t2_mul_a2", mul_a,   8);
        @(negedge clk);
        checkOutput("t2_done2", done_cnt, 3);

        $display("[TB] timeout with dead multiplier");
        ackEnable = 1'b0;
        applyStimulus(8'd3, 8'd3);
        waitRsp(cyc);
        checkOutput("t3_lat",  cyc,      TO + 2);
        checkOutput("t3_data", rsp_data, 0);
        checkOutput("t3_err",  rsp_err,  1);
        @(negedge clk);
        checkOutput("t3_errcnt",  err_cnt,  1);
        checkOutput("t3_donecnt", done_cnt, 3);
        ackEnable = 1'b1;

        $display("[TB] width corners");
        applyStimulus(8'd255, 8'd255);
        waitRsp(cyc);
        checkOutput("t4_full",     rsp_data, 65025);
        checkOutput("t4_full_err", rsp_err,  0);
        @(negedge clk);
        applyStimulus(8'd0, 8'd200);
        waitRsp(cyc);
        checkOutput("t4_zero",     rsp_data, 0);
        checkOutput("t4_zero_err", rsp_err,  0);
        @(negedge clk);
        checkOutput("t4_done", done_cnt, 5);

        $display("[TB] stray acks");
        strayAck = 1'b1;
        @(negedge clk);
        strayAck = 1'b0;
        @(negedge clk);
        checkOutput("t6i_ready", req_ready, 1);
        checkOutput("t6i_busy",  busy,      0);
        checkOutput("t6i_valid", rsp_valid, 0);
        checkOutput("t6i_data",  rsp_data,  0);
        checkOutput("t6i_done",  done_cnt,  5);
        checkOutput("t6i_err",   err_cnt,   1);
        rsp_ready = 1'b0;
        applyStimulus(8'd7, 8'd9);
        waitRsp(cyc);
        checkOutput("t6r_data0", rsp_data, 63);
        strayAck = 1'b1;
        @(negedge clk);
        strayAck = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("t6r_valid", rsp_valid, 1);
        checkOutput("t6r_data",  rsp_data,  63);
        checkOutput("t6r_errf",  rsp_err,   0);
        checkOutput("t6r_done",  done_cnt,  5);
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("t6r_done2", done_cnt, 6);

        $display("[TB] reset during WAIT");
        ackEnable = 1'b0;
        applyStimulus(8'd9, 8'd9);
        repeat (3) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        checkOutput("t5_busy_before", busy, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("t5_ready", req_ready, 1);
        checkOutput("t5_valid", rsp_valid, 0);
        checkOutput("t5_busy",  busy,      0);
        checkOutput("t5_done",  done_cnt,  0);
        checkOutput("t5_err",   err_cnt,   0);
        checkOutput("t5_mul_en", mul_en,   0);
        @(negedge clk);
        reset_n   = 1'b1;
        ackEnable = 1'b1;
        @(negedge clk);
        applyStimulus(8'd5, 8'd5);
        waitRsp(cyc);
        checkOutput("t5_lat",  cyc,      3);
        checkOutput("t5_data", rsp_data, 25);
        @(negedge clk);
        checkOutput("t5_done2", done_cnt, 1);

        $display("[TB] randomized operations");
        expDone = 1;
        expErr  = 0;
        for (int n = 0; n < 40; n++) begin
            ra      = DW'($urandom);
            rb      = DW'($urandom);
            latCfg  = $urandom_range(1, 10);
            expE    = (latCfg > TO);
            expData = expE ? '0 : ra * rb;
            rsp_ready = 1'b0;
            checkOutput("rnd_ready", req_ready, 1);
            applyStimulus(ra, rb);
            handshook = 1'b0;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                req_valid = 1'b0;
                if (rsp_valid) begin
                    checkOutput("rnd_data", rsp_data, expData);
                    checkOutput("rnd_err",  rsp_err,  expE);
                end
                rsp_ready = 1'($urandom_range(0, 1));
                if (rsp_valid && rsp_ready) begin
                    handshook = 1'b1;
                    break;
                end
            end
            checkOutput("rnd_handshake", handshook, 1);
            if (expE) expErr++;
            else      expDone++;
            @(negedge clk);
            rsp_ready = 1'b0;
            checkOutput("rnd_done_cnt", done_cnt, expDone);
            checkOutput("rnd_err_cnt",  err_cnt,  expErr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
